// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer: state encodings,
// BCD digit limits and the preset clamp helper.
package countdown_timer_bcd_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Control/display bundle between the keypad/preset logic and the countdown timer.
interface countdown_timer_bcd_if;

  logic        tick;
  logic        load;
  logic [15:0] preset;
  logic        start;
  logic        pause;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic        running;
  logic        expired;
  logic        done;

  modport master (
    output tick, load, preset, start, pause,
    input  min_tens, min_ones, sec_tens, sec_ones, running, expired, done
  );

  modport slave (
    input  tick, load, preset, start, pause,
    output min_tens, min_ones, sec_tens, sec_ones, running, expired, done
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter: decrements when borrow_in is set,
// wrapping 0 -> MAX and passing the borrow on.
module bcd_down_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  localparam logic [3:0] MAX_D = 4'(MAX);

  always_comb begin
    next_digit = digit;
    if (borrow_in)
      next_digit = (digit == 4'd0) ? MAX_D : (digit - 4'd1);
  end

  assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// mm:ss BCD countdown timer: loads a clamped preset, decrements on each 1 Hz
// tick while running, and flags expiry with a one-cycle done pulse at 00:00.
module countdown_timer_bcd
  import countdown_timer_bcd_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input logic clkinput,
  input logic reset,
  countdown_timer_bcd_if.slave bus
);

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  logic [1:0]  state, state_n;
  logic [15:0] value, value_n;
  logic [15:0] reload, reload_n;
  logic        done_n;

  logic [15:0] preset_clamped;
  logic [15:0] dec_value;
  logic        b_so, b_st, b_mo, b_mt;

  assign preset_clamped = {clamp_bcd(bus.preset[15:12], MT_MAX),
                           clamp_bcd(bus.preset[11:8],  BCD_ONES_MAX),
                           clamp_bcd(bus.preset[7:4],   BCD_TENS_MAX),
                           clamp_bcd(bus.preset[3:0],   BCD_ONES_MAX)};

  // Borrow chain seeded with 1 at sec_ones so the chain yields value - 1 s.
  bcd_down_digit #(.MAX(9)) u_sec_ones (
    .digit(value[3:0]),   .borrow_in(1'b1), .next_digit(dec_value[3:0]),   .borrow_out(b_so)
  );
  bcd_down_digit #(.MAX(5)) u_sec_tens (
    .digit(value[7:4]),   .borrow_in(b_so), .next_digit(dec_value[7:4]),   .borrow_out(b_st)
  );
  bcd_down_digit #(.MAX(9)) u_min_ones (
    .digit(value[11:8]),  .borrow_in(b_st), .next_digit(dec_value[11:8]),  .borrow_out(b_mo)
  );
  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .digit(value[15:12]), .borrow_in(b_mo), .next_digit(dec_value[15:12]), .borrow_out(b_mt)
  );

  // Events that do not apply in the current state fall through to lower priority.
  always_comb begin
    state_n  = state;
    value_n  = value;
    reload_n = reload;
    done_n   = 1'b0;
    if (bus.load && state != ST_RUN) begin
      value_n  = preset_clamped;
      reload_n = preset_clamped;
      state_n  = ST_IDLE;
    end else if (bus.pause && state == ST_RUN) begin
      state_n = ST_PAUSE;
    end else if (bus.start && (state == ST_IDLE || state == ST_PAUSE)) begin
      if (value != '0)
        state_n = ST_RUN;
    end else if (bus.start && state == ST_EXPIRED) begin
      value_n = reload;
      state_n = (reload != '0) ? ST_RUN : ST_IDLE;
    end else if (bus.tick && state == ST_RUN) begin
      value_n = dec_value;
      if (dec_value == '0) begin
        state_n = ST_EXPIRED;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clkinput or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      value       <= '0;
      reload      <= '0;
      bus.running <= 1'b0;
      bus.expired <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_n;
      value       <= value_n;
      reload      <= reload_n;
      bus.running <= (state_n == ST_RUN);
      bus.expired <= (state_n == ST_EXPIRED);
      bus.done    <= done_n;
    end
  end

  assign bus.min_tens = value[15:12];
  assign bus.min_ones = value[11:8];
  assign bus.sec_tens = value[7:4];
  assign bus.sec_ones = value[3:0];

  logic unused_borrow;
  assign unused_borrow = b_mt;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd: load/clamp, borrow chain, pause,
// expiry/done pulse, restart from EXPIRED and asynchronous reset.
module tb_countdown_timer_bcd;

  logic clkinput;
  logic reset;
  int   n_tests;
  int   n_failed;

  countdown_timer_bcd_if bus ();

  countdown_timer_bcd #(.MIN_TENS_MAX(5)) dut (
    .clkinput(clkinput),
    .reset(reset),
    .bus(bus)
  );

  initial clkinput = 1'b0;
  always #5 clkinput = ~clkinput;

  function automatic logic [15:0] digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkinput);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1; bus.preset = v;
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_ticks(input int unsigned n);
    bus.tick = 1'b1;
    repeat (n) step();
    bus.tick = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_failed = 0;
    reset = 1'b0;
    bus.tick = 1'b0; bus.load = 1'b0; bus.preset = '0;
    bus.start = 1'b0; bus.pause = 1'b0;
    repeat (2) step();
    check("rst_digits",  32'(digits()),   32'h0000);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_expired", 32'(bus.expired), 32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    reset = 1'b1;
    step();

    // Full borrow chain
    do_load(16'h1000);
    check("load_1000", 32'(digits()), 32'h1000);
    do_start();
    check("start_run", 32'(bus.running), 32'd1);
    do_ticks(1);
    check("chain_0959", 32'(digits()), 32'h0959);

    // load ignored in RUN
    do_load(16'h0100);
    check("load_in_run", 32'(digits()), 32'h0959);
    check("run_after_load", 32'(bus.running), 32'd1);
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
    check("pause_running", 32'(bus.running), 32'd0);
    check("pause_hold", 32'(digits()), 32'h0959);

    // 01:00 down to expiry
    do_load(16'h0100);
    check("load_0100", 32'(digits()), 32'h0100);
    do_start();
    do_ticks(1);
    check("tick_0059", 32'(digits()), 32'h0059);
    do_ticks(58);
    check("tick_0001", 32'(digits()), 32'h0001);
    check("no_early_done", 32'(bus.done), 32'd0);
    do_ticks(1);
    check("exp_digits", 32'(digits()), 32'h0000);
    check("exp_done",   32'(bus.done), 32'd1);
    check("exp_flag",   32'(bus.expired), 32'd1);
    check("exp_running", 32'(bus.running), 32'd0);
    do_ticks(1);
    check("done_clears", 32'(bus.done), 32'd0);
    check("no_wrap", 32'(digits()), 32'h0000);
    check("exp_hold", 32'(bus.expired), 32'd1);

    // Restart from EXPIRED reloads 00:02
    do_load(16'h0002);
    check("load_exp_idle", 32'(bus.expired), 32'd0);
    do_start();
    do_ticks(2);
    check("exp2_done", 32'(bus.done), 32'd1);
    do_start();
    check("restart_digits", 32'(digits()), 32'h0002);
    check("restart_run", 32'(bus.running), 32'd1);
    check("restart_exp", 32'(bus.expired), 32'd0);
    do_ticks(1);
    check("restart_0001", 32'(digits()), 32'h0001);
    do_ticks(1);
    check("restart_done", 32'(bus.done), 32'd1);

    // Clamp and zero start
    do_load(16'hFC7A);
    check("clamp", 32'(digits()), 32'h5959);
    check("clamp_state", 32'(bus.expired), 32'd0);
    do_load(16'h0000);
    do_start();
    check("zero_start_run", 32'(bus.running), 32'd0);
    check("zero_start_done", 32'(bus.done), 32'd0);
    check("zero_start_exp", 32'(bus.expired), 32'd0);

    // pause beats tick
    do_load(16'h0005);
    do_start();
    bus.pause = 1'b1; bus.tick = 1'b1; step();
    bus.pause = 1'b0; bus.tick = 1'b0;
    check("pause_tick_hold", 32'(digits()), 32'h0005);
    check("pause_tick_run", 32'(bus.running), 32'd0);
    do_ticks(1);
    check("tick_in_pause", 32'(digits()), 32'h0005);
    do_start();
    do_ticks(5);
    check("resume_0000", 32'(digits()), 32'h0000);
    check("resume_done", 32'(bus.done), 32'd1);

    // Async reset mid-RUN
    do_load(16'h0327);
    do_start();
    #2 reset = 1'b0;
    #1;
    check("async_digits", 32'(digits()), 32'h0000);
    check("async_running", 32'(bus.running), 32'd0);
    step();
    reset = 1'b1;
    do_start();
    check("reload_lost", 32'(bus.running), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
